// File: rtl/osc_phase_gen.sv
// Oscillator phase generator: phase counter per note period, periodic divider start with frozen operands.
// Latency: flag/count/divider one cycle after the sampling edge; sample_valid DIV_LATENCY cycles after flag.
// Backpressure: none; the downstream divider must accept a start every SAMPLE_DIV cycles.
module osc_phase_gen #(
    parameter int unsigned SAMPLE_DIV  = 256,
    parameter int unsigned DIV_LATENCY = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        note_en,
    input  logic [15:0] divider_in,
    output logic        flag,
    output logic [15:0] count,
    output logic [15:0] divider,
    output logic        sample_valid,
    output logic        active
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(SAMPLE_DIV - 1);

    state_t      state_q, state_n;
    logic [15:0] phase_q, phase_n;
    logic [15:0] adiv_q, adiv_n;
    logic [15:0] timer_q, timer_n;
    logic        rel_q, rel_n;
    logic        div_ok;
    logic        wrap;
    logic        flag_n;
    logic [DIV_LATENCY-1:0] vld_pipe_q;

    // Next-cycle values are computed here so that flag and its operands
    // are registered and appear together in the flag cycle itself.
    always_comb begin
        state_n = state_q;
        phase_n = phase_q;
        adiv_n  = adiv_q;
        timer_n = timer_q;
        rel_n   = rel_q;
        div_ok  = (divider_in >= 16'd2);
        wrap    = (state_q == RUN) && (phase_q == adiv_q - 16'd1);

        case (state_q)
            IDLE: begin
                phase_n = 16'd0;
                timer_n = 16'd0;
                rel_n   = 1'b0;
                if (note_en && div_ok) begin
                    state_n = RUN;
                    adiv_n  = divider_in;
                end
            end
            RUN: begin
                timer_n = (timer_q == TIMER_LAST) ? 16'd0 : timer_q + 16'd1;
                rel_n   = !note_en;
                if (wrap) begin
                    phase_n = 16'd0;
                    if (div_ok) begin
                        adiv_n = divider_in;
                    end
                    if (rel_q) begin
                        state_n = IDLE;
                        rel_n   = 1'b0;
                    end
                end else begin
                    phase_n = phase_q + 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        flag_n = (state_n == RUN) && (timer_n == 16'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= 16'd0;
            adiv_q     <= 16'd0;
            timer_q    <= 16'd0;
            rel_q      <= 1'b0;
            flag       <= 1'b0;
            count      <= 16'd0;
            divider    <= 16'd0;
            vld_pipe_q <= '0;
        end else begin
            state_q <= state_n;
            phase_q <= phase_n;
            adiv_q  <= adiv_n;
            timer_q <= timer_n;
            rel_q   <= rel_n;
            flag    <= flag_n;
            // Operands move only on a start so the divider sees them frozen.
            if (flag_n) begin
                count   <= phase_n;
                divider <= adiv_n;
            end else if (state_n == IDLE) begin
                count <= 16'd0;
            end
            vld_pipe_q[0] <= flag;
            for (int i = 1; i < int'(DIV_LATENCY); i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
            end
        end
    end

    assign sample_valid = vld_pipe_q[DIV_LATENCY-1];
    assign active       = (state_q == RUN);

endmodule

// File: tb/tb_osc_phase_gen.sv
// Bench for osc_phase_gen: directed scenarios with constant expectations plus
// randomized traffic against a cycle-indexed reference model.
module tb_osc_phase_gen;

    localparam int SD = 256;
    localparam int DL = 12;

    logic        tb_clk = 1'b0;
    logic        rst = 1'b0;
    logic        note_en = 1'b0;
    logic [15:0] divider_in = 16'd0;
    logic        flag;
    logic [15:0] count;
    logic [15:0] divider;
    logic        sample_valid;
    logic        active;

    int checks = 0;
    int errors = 0;

    // Reference model state: note timing kept as absolute cycle indices.
    int          cyc = 0;
    bit          m_run = 1'b0;
    int          m_phase = 0;
    int          m_period = 0;
    int          m_start = 0;
    bit          m_rel = 1'b0;
    bit          m_flag = 1'b0;
    bit          m_sv = 1'b0;
    logic [15:0] m_count = 16'd0;
    logic [15:0] m_divider = 16'd0;
    int          fq[$];

    osc_phase_gen #(.SAMPLE_DIV(SD), .DIV_LATENCY(DL)) dut (
        .clk(tb_clk),
        .rst(rst),
        .note_en(note_en),
        .divider_in(divider_in),
        .flag(flag),
        .count(count),
        .divider(divider),
        .sample_valid(sample_valid),
        .active(active)
    );

    always #50 tb_clk = ~tb_clk;

    function automatic void model_step();
        int nxt;
        nxt = cyc + 1;
        if (rst) begin
            m_run = 1'b0; m_phase = 0; m_period = 0; m_rel = 1'b0;
            m_count = 16'd0; m_divider = 16'd0; m_flag = 1'b0;
            fq.delete();
        end else begin
            if (!m_run) begin
                if (note_en && divider_in >= 16'd2) begin
                    m_run = 1'b1; m_phase = 0; m_period = int'(divider_in);
                    m_start = nxt; m_rel = 1'b0;
                end
            end else if (m_phase == m_period - 1) begin
                m_phase = 0;
                if (divider_in >= 16'd2) m_period = int'(divider_in);
                if (m_rel) m_run = 1'b0;
                m_rel = m_run && !note_en;
            end else begin
                m_phase = m_phase + 1;
                m_rel = !note_en;
            end
            m_flag = m_run && (((nxt - m_start) % SD) == 0);
            if (m_flag) begin
                m_count = 16'(m_phase);
                m_divider = 16'(m_period);
                fq.push_back(nxt);
            end else if (!m_run) begin
                m_count = 16'd0;
            end
        end
        while (fq.size() > 0 && fq[0] < nxt - DL) void'(fq.pop_front());
        m_sv = (fq.size() > 0) && (fq[0] == nxt - DL);
        cyc = nxt;
    endfunction

    task automatic tick();
        @(posedge tb_clk);
        model_step();
        #1;
    endtask

    // Resets, then presses a note; returns in offset 1 (first RUN cycle).
    task automatic start_note(input logic [15:0] div);
        note_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        divider_in = div;
        note_en = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        note_en = 1'b0;
        divider_in = 16'd22727;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({flag, count, divider, sample_valid, active} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs got flag=%b count=%0d div=%0d sv=%b act=%b want all 0",
                     flag, count, divider, sample_valid, active);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (active !== 1'b0 || flag !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_note got act=%b flag=%b want 0 0", active, flag);
            end
        end
        start_note(16'd22727);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({flag, count, divider, sample_valid, active} !== 35'd0) begin
                errors++;
                $display("FAIL reset_midrun got flag=%b count=%0d div=%0d sv=%b act=%b want all 0",
                         flag, count, divider, sample_valid, active);
            end
        end
        note_en = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (sample_valid !== 1'b0 || active !== 1'b0) begin
                errors++;
                $display("FAIL reset_flush got sv=%b act=%b want 0 0", sample_valid, active);
            end
        end
    endtask

    task automatic test_a4_start();
        start_note(16'd22727);
        for (int off = 1; off <= 513; off++) begin
            if (off > 1) tick();
            checks++;
            if (flag !== (((off - 1) % SD) == 0)) begin
                errors++;
                $display("FAIL a4_flag off=%0d got %b want %b", off, flag, ((off - 1) % SD) == 0);
            end
            if (off == 1 || off == 257 || off == 513) begin
                checks++;
                if (count !== 16'(off - 1) || divider !== 16'd22727 || active !== 1'b1) begin
                    errors++;
                    $display("FAIL a4_operands off=%0d got count=%0d div=%0d act=%b want %0d 22727 1",
                             off, count, divider, active, off - 1);
                end
            end
            if (off == 12 || off == 13 || off == 14 || off == 269) begin
                checks++;
                if (sample_valid !== (off == 13 || off == 269)) begin
                    errors++;
                    $display("FAIL a4_sample_valid off=%0d got %b want %b", off, sample_valid,
                             off == 13 || off == 269);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_w[4];
        exp_w = '{16'd0, 16'd256, 16'd212, 16'd168};
        start_note(16'd300);
        for (int off = 1; off <= 769; off++) begin
            if (off > 1) tick();
            if (((off - 1) % SD) == 0) begin
                checks++;
                if (flag !== 1'b1 || count !== exp_w[(off - 1) / SD] || divider !== 16'd300) begin
                    errors++;
                    $display("FAIL wrap_flag off=%0d got flag=%b count=%0d div=%0d want 1 %0d 300",
                             off, flag, count, divider, exp_w[(off - 1) / SD]);
                end
            end
        end
    endtask

    task automatic test_period_change();
        start_note(16'd300);
        for (int off = 1; off <= 1025; off++) begin
            if (off > 1) begin
                if (off == 102) divider_in = 16'd500;
                tick();
            end
            if (off == 257) begin
                checks++;
                if (flag !== 1'b1 || count !== 16'd256 || divider !== 16'd300) begin
                    errors++;
                    $display("FAIL pchg_old off=257 got flag=%b count=%0d div=%0d want 1 256 300",
                             flag, count, divider);
                end
            end
            if (off == 513 || off == 769 || off == 1025) begin
                checks++;
                if (flag !== 1'b1 || divider !== 16'd500 ||
                    count !== (off == 513 ? 16'd212 : off == 769 ? 16'd468 : 16'd224)) begin
                    errors++;
                    $display("FAIL pchg_new off=%0d got flag=%b count=%0d div=%0d want 1 %0d 500",
                             off, flag, count, divider,
                             off == 513 ? 212 : off == 769 ? 468 : 224);
                end
            end
        end
    endtask

    task automatic test_release();
        start_note(16'd300);
        for (int off = 1; off <= 310; off++) begin
            if (off > 1) begin
                if (off == 52) note_en = 1'b0;
                tick();
            end
            if (off == 300 || off == 301 || off == 310) begin
                checks++;
                if (active !== (off == 300) || (off != 300 && (flag !== 1'b0 || count !== 16'd0 ||
                                                                divider !== 16'd300))) begin
                    errors++;
                    $display("FAIL release off=%0d got act=%b flag=%b count=%0d div=%0d want act=%b",
                             off, active, flag, count, divider, off == 300);
                end
            end
        end
        start_note(16'd260);
        for (int off = 1; off <= 275; off++) begin
            if (off > 1) begin
                if (off == 52) note_en = 1'b0;
                tick();
            end
            if (off == 261 || off == 269 || off == 270) begin
                checks++;
                if (active !== 1'b0 || flag !== 1'b0 || count !== 16'd0 ||
                    sample_valid !== (off == 269)) begin
                    errors++;
                    $display("FAIL release_inflight off=%0d got act=%b flag=%b count=%0d sv=%b want sv=%b",
                             off, active, flag, count, sample_valid, off == 269);
                end
            end
        end
        start_note(16'd300);
        for (int off = 1; off <= 513; off++) begin
            if (off > 1) begin
                if (off == 52) note_en = 1'b0;
                if (off == 202) note_en = 1'b1;
                tick();
            end
            if (off == 301 || off == 400 || off == 513) begin
                checks++;
                if (active !== 1'b1 || (off == 513 && (flag !== 1'b1 || count !== 16'd212))) begin
                    errors++;
                    $display("FAIL repress off=%0d got act=%b flag=%b count=%0d want active", off,
                             active, flag, count);
                end
            end
        end
    endtask

    task automatic test_illegal_divider();
        start_note(16'd1);
        for (int i = 0; i < 30; i++) begin
            if (i == 20) divider_in = 16'd0;
            tick();
            checks++;
            if (active !== 1'b0 || flag !== 1'b0) begin
                errors++;
                $display("FAIL illegal_div=%0d got act=%b flag=%b want 0 0", divider_in, active, flag);
            end
        end
        divider_in = 16'd2;
        tick();
        for (int off = 1; off <= 513; off++) begin
            if (off > 1) tick();
            if (off == 1 || off == 2 || off == 257 || off == 513) begin
                checks++;
                if (active !== 1'b1 || flag !== (off != 2) || count !== 16'd0 || divider !== 16'd2) begin
                    errors++;
                    $display("FAIL div2 off=%0d got act=%b flag=%b count=%0d div=%0d want 1 %b 0 2",
                             off, active, flag, count, divider, off != 2);
                end
            end
        end
    endtask

    task automatic test_random();
        note_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 149) == 0) note_en = !note_en;
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 3))
                    0: divider_in = 16'($urandom_range(0, 1));
                    1: divider_in = 16'($urandom_range(2, 5));
                    2: divider_in = 16'($urandom_range(200, 700));
                    default: divider_in = 16'($urandom_range(2, 65535));
                endcase
            end
            rst = ($urandom_range(0, 1499) == 0);
            tick();
            checks++;
            if (flag !== m_flag || active !== m_run || sample_valid !== m_sv ||
                count !== m_count || divider !== m_divider) begin
                errors++;
                $display("FAIL random cyc=%0d got f=%b a=%b sv=%b c=%0d d=%0d want f=%b a=%b sv=%b c=%0d d=%0d",
                         cyc, flag, active, sample_valid, count, divider,
                         m_flag, m_run, m_sv, m_count, m_divider);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_a4_start();
        test_wrap();
        test_period_change();
        test_release();
        test_illegal_divider();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
